// File: rtl/bbox_tracker.sv
// bbox_tracker: sequences the min/max filter start/ack handshake, validates and tracks the box,
// and publishes box/centre on frame_tick. Optional coordinate smoothing: `BBOX_SMOOTH_EN.
module bbox_tracker #(
  parameter int COORD_W     = 9,
  parameter int X_LIM       = 319,
  parameter int Y_LIM       = 239,
  parameter int MIN_SIZE    = 4,
  parameter int MISS_LIMIT  = 8,
  parameter int SHIFT       = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  output logic               start_flag,
  output logic               ack_flag,
  input  logic               done_flag,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [COORD_W-1:0] x_cen,
  output logic [COORD_W-1:0] y_cen,
  output logic               box_valid,
  output logic               lost,
  output logic [3:0]         miss_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, CAPTURE, ACK_WAIT, UPDATE} state_t;
  state_t state, state_nx;

  logic [TW-1:0]      timer;
  logic               timer_hit, timed_out;
  logic [COORD_W-1:0] raw_x_min, raw_x_max, raw_y_min, raw_y_max;
  logic [COORD_W-1:0] pend_x_min, pend_x_max, pend_y_min, pend_y_max;
  logic [COORD_W:0]   w_x, w_y, sum_x, sum_y;
  logic [3:0]         miss_p, miss_inc;
  logic               lost_p, ever_valid, raw_ok, miss_lim;

  // Step toward target by (in - p) >>> SHIFT, never stalling on a non-zero difference.
  function automatic logic [COORD_W-1:0] smooth(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] in);
    logic signed [COORD_W:0] d, step;
    d    = $signed({1'b0, in}) - $signed({1'b0, p});
    step = d >>> SHIFT;
    if (step == '0 && d != '0)
      step = d[COORD_W] ? '1 : $signed((COORD_W+1)'(1));
    return p + step[COORD_W-1:0];
  endfunction

  assign timer_hit = (timer == TW'(TIMEOUT_CYC - 1));
  assign w_x       = {1'b0, raw_x_max} - {1'b0, raw_x_min} + (COORD_W+1)'(1);
  assign w_y       = {1'b0, raw_y_max} - {1'b0, raw_y_min} + (COORD_W+1)'(1);
  assign raw_ok    = (raw_x_min <= raw_x_max) && (raw_y_min <= raw_y_max) &&
                     (raw_x_max <= COORD_W'(X_LIM)) && (raw_y_max <= COORD_W'(Y_LIM)) &&
                     (w_x >= (COORD_W+1)'(MIN_SIZE)) && (w_y >= (COORD_W+1)'(MIN_SIZE));
  assign miss_inc  = (miss_p == 4'hF) ? miss_p : miss_p + 4'd1;
  assign miss_lim  = (miss_inc >= 4'(MISS_LIMIT));
  assign sum_x     = {1'b0, pend_x_min} + {1'b0, pend_x_max};
  assign sum_y     = {1'b0, pend_y_min} + {1'b0, pend_y_max};

`ifdef BBOX_SMOOTH_EN
  logic reacq;
  assign reacq = lost_p | ~ever_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_flag = 1'b0;
    ack_flag   = 1'b0;
    case (state)
      IDLE:      if (enable && !done_flag) state_nx = START;
      START: begin
        start_flag = 1'b1;
        state_nx   = WAIT_DONE;
      end
      WAIT_DONE: begin
        start_flag = 1'b1;
        if (done_flag)      state_nx = CAPTURE;
        else if (timer_hit) state_nx = ACK_WAIT;
      end
      CAPTURE: begin
        ack_flag = 1'b1;
        state_nx = ACK_WAIT;
      end
      ACK_WAIT: begin
        ack_flag = 1'b1;
        if (!done_flag) state_nx = timed_out ? IDLE : UPDATE;
      end
      UPDATE:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      timed_out  <= 1'b0;
      raw_x_min  <= '0;
      raw_x_max  <= '0;
      raw_y_min  <= '0;
      raw_y_max  <= '0;
      pend_x_min <= '0;
      pend_x_max <= '0;
      pend_y_min <= '0;
      pend_y_max <= '0;
      miss_p     <= '0;
      lost_p     <= 1'b1;
      ever_valid <= 1'b0;
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      x_cen      <= '0;
      y_cen      <= '0;
      box_valid  <= 1'b0;
      lost       <= 1'b1;
      miss_cnt   <= '0;
    end else begin
      case (state)
        START: begin
          timer     <= '0;
          timed_out <= 1'b0;
        end
        WAIT_DONE: begin
          timer <= timer + TW'(1);
          if (!done_flag && timer_hit) begin
            timed_out <= 1'b1;
            miss_p    <= miss_inc;
            lost_p    <= lost_p | miss_lim;
          end
        end
        CAPTURE: begin
          raw_x_min <= x_min;
          raw_x_max <= x_max;
          raw_y_min <= y_min;
          raw_y_max <= y_max;
        end
        UPDATE: begin
          if (raw_ok) begin
`ifdef BBOX_SMOOTH_EN
            if (!reacq) begin
              pend_x_min <= smooth(pend_x_min, raw_x_min);
              pend_x_max <= smooth(pend_x_max, raw_x_max);
              pend_y_min <= smooth(pend_y_min, raw_y_min);
              pend_y_max <= smooth(pend_y_max, raw_y_max);
            end else
`endif
            begin
              pend_x_min <= raw_x_min;
              pend_x_max <= raw_x_max;
              pend_y_min <= raw_y_min;
              pend_y_max <= raw_y_max;
            end
            ever_valid <= 1'b1;
            lost_p     <= 1'b0;
            miss_p     <= '0;
          end else begin
            miss_p <= miss_inc;
            lost_p <= lost_p | miss_lim;
          end
        end
        default: ;
      endcase

      // A tick during UPDATE publishes the values held before this cycle's update.
      if (frame_tick) begin
        box_x_min <= pend_x_min;
        box_x_max <= pend_x_max;
        box_y_min <= pend_y_min;
        box_y_max <= pend_y_max;
        x_cen     <= COORD_W'(sum_x >> 1);
        y_cen     <= COORD_W'(sum_y >> 1);
        box_valid <= ever_valid & ~lost_p;
        lost      <= lost_p;
        miss_cnt  <= miss_p;
      end
    end
  end

endmodule
